i2c_slave: RTL



---
 rtl/i2c_slave_if.sv | 22 ++
 rtl/i2c_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_if.sv
// Bus/register-port bundle between the I2C target and its environment.
// The slave modport is the target's view; master is the pad/register-file side.
interface i2c_slave_if;
    logic       i2c_clk;
    logic       i2c_sda;
    logic       sda_oen;
    logic [7:0] reg_addr;
    logic [7:0] reg_rdata;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       busy;

    modport slave (
        input  i2c_clk, i2c_sda, reg_rdata,
        output sda_oen, reg_addr, reg_wdata, reg_we, busy
    );

    modport master (
        output i2c_clk, i2c_sda, reg_rdata,
        input  sda_oen, reg_addr, reg_wdata, reg_we, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with register pointer: oversampled SCL/SDA, START/STOP detect,
// pointer byte then write bytes or auto-incrementing read bytes.
module i2c_slave #(
    parameter logic [6:0] DEVICE_ADDR = 7'h50,
    parameter int         SDA_HOLD    = 4
) (
    input  logic        clk,
    input  logic        rst,
    i2c_slave_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    state_t      state, state_n;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_d, sda_d;
    logic        scl, sda;
    logic        scl_rise, scl_fall, start, stop;
    logic [SDA_HOLD-1:0] hold_pipe;
    logic        fall_act;

    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_cnt, cnt_n;
    logic        byte_done, done_n;
    logic        rw, rw_n;
    logic        inc_pend, inc_n;
    logic        oen_q, oen_n;
    logic [7:0]  addr_q, addr_n;
    logic [7:0]  wdata_q, wdata_n;
    logic        we_q, we_n;
    logic        busy_q, busy_n;

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start    = scl & scl_d & sda_d & ~sda;
    assign stop     = scl & scl_d & ~sda_d & sda;
    assign fall_act = hold_pipe[SDA_HOLD-1];

    assign bus.sda_oen   = oen_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = we_q;
    assign bus.busy      = busy_q;

    // Synchronizers reset to the idle-bus level so release of reset is not seen as an edge on SDA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            hold_pipe <= '0;
        end else begin
            scl_sync  <= {scl_sync[0], bus.i2c_clk};
            sda_sync  <= {sda_sync[0], bus.i2c_sda};
            scl_d     <= scl;
            sda_d     <= sda;
            if (start || stop)
                hold_pipe <= '0;
            else
                hold_pipe <= {hold_pipe[SDA_HOLD-2:0], scl_fall};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= 3'd7;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            inc_pend  <= 1'b0;
            oen_q     <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= cnt_n;
            byte_done <= done_n;
            rw        <= rw_n;
            inc_pend  <= inc_n;
            oen_q     <= oen_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            we_q      <= we_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = bit_cnt;
        done_n  = byte_done;
        rw_n    = rw;
        inc_n   = 1'b0;
        oen_n   = oen_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        we_n    = 1'b0;
        busy_n  = busy_q;

        // Write pointer advances the clk after the strobe so reg_we sees the old address.
        if (inc_pend)
            addr_n = addr_q + 8'd1;

        if (start) begin
            state_n = ADDR;
            cnt_n   = 3'd7;
            done_n  = 1'b0;
            oen_n   = 1'b1;
        end else if (stop) begin
            state_n = IDLE;
            done_n  = 1'b0;
            oen_n   = 1'b1;
            busy_n  = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, REG, WDATA: begin
                    shreg_n = {shreg[6:0], sda};
                    cnt_n   = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0)
                        done_n = 1'b1;
                end
                RDATA_ACK: begin
                    if (!sda) begin
                        addr_n = addr_q + 8'd1;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = WAIT;
                    end
                end
                default: ;
            endcase
        end else if (fall_act) begin
            case (state)
                ADDR: begin
                    if (byte_done) begin
                        done_n = 1'b0;
                        if (shreg[7:1] == DEVICE_ADDR) begin
                            oen_n   = 1'b0;
                            busy_n  = 1'b1;
                            rw_n    = shreg[0];
                            state_n = ADDR_ACK;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = WAIT;
                        end
                    end
                end
                ADDR_ACK, RDATA_ACK: begin
                    if (state == RDATA_ACK || rw) begin
                        shreg_n = bus.reg_rdata;
                        oen_n   = bus.reg_rdata[7];
                        cnt_n   = 3'd7;
                        state_n = RDATA;
                    end else begin
                        oen_n   = 1'b1;
                        state_n = REG;
                    end
                end
                REG: begin
                    if (byte_done) begin
                        done_n  = 1'b0;
                        addr_n  = shreg;
                        oen_n   = 1'b0;
                        state_n = REG_ACK;
                    end
                end
                WDATA: begin
                    if (byte_done) begin
                        done_n  = 1'b0;
                        wdata_n = shreg;
                        we_n    = 1'b1;
                        inc_n   = 1'b1;
                        oen_n   = 1'b0;
                        state_n = WDATA_ACK;
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    oen_n   = 1'b1;
                    state_n = WDATA;
                end
                RDATA: begin
                    if (bit_cnt == 3'd0) begin
                        oen_n   = 1'b1;
                        state_n = RDATA_ACK;
                    end else begin
                        shreg_n = {shreg[6:0], 1'b0};
                        oen_n   = shreg[6];
                        cnt_n   = bit_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
